// File: rtl/clk_delay_pkg.sv
// Shared types and helpers for the pixel-clock delay-line calibration and the delay-mux wrapper.
package clk_delay_pkg;

    localparam int NTAPS_DEF = 8;
    localparam int TAP_W_DEF = 3;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        EVAL,
        APPLY
    } calState_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/clk_delay_tap_calib_if.sv
// Host/checker-side bundle of the tap calibrator: control, checker results, tap select and status.
interface clk_delay_tap_calib_if
    import clk_delay_pkg::*;
#(
    parameter int TAP_W = TAP_W_DEF
);
    logic             iSTART;
    logic             iMANUAL_EN;
    logic [TAP_W-1:0] iMANUAL_TAP;
    logic             iCHK_VALID;
    logic             iCHK_ERR;
    logic [TAP_W-1:0] oTAP_SEL;
    logic             oBUSY;
    logic             oDONE;
    logic             oLOCKED;
    logic             oFAIL;
    logic [TAP_W-1:0] oWIN_START;
    logic [TAP_W:0]   oWIN_LEN;

    modport master (
        output iSTART, iMANUAL_EN, iMANUAL_TAP, iCHK_VALID, iCHK_ERR,
        input  oTAP_SEL, oBUSY, oDONE, oLOCKED, oFAIL, oWIN_START, oWIN_LEN
    );

    modport slave (
        input  iSTART, iMANUAL_EN, iMANUAL_TAP, iCHK_VALID, iCHK_ERR,
        output oTAP_SEL, oBUSY, oDONE, oLOCKED, oFAIL, oWIN_START, oWIN_LEN
    );
endinterface

// File: rtl/clk_delay_run_tracker.sv
// Tracks the current and longest run of passing taps during a sweep and gives the centre of the best run.
module clk_delay_run_tracker
    import clk_delay_pkg::*;
#(
    parameter int TAP_W = TAP_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             evalEn,
    input  logic             pass,
    input  logic [TAP_W-1:0] tap,
    output logic [TAP_W-1:0] bestStart,
    output logic [TAP_W:0]   bestLen,
    output logic [TAP_W-1:0] centreTap
);
    logic [TAP_W-1:0] curStart, curStartNew;
    logic [TAP_W:0]   curLen, curLenNew;
    logic [TAP_W:0]   halfSpan;

    always_comb begin
        curLenNew   = pass ? curLen + 1'b1 : '0;
        curStartNew = (pass && curLen == '0) ? tap : curStart;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            curStart  <= '0;
            curLen    <= '0;
            bestStart <= '0;
            bestLen   <= '0;
        end else if (clear) begin
            curStart  <= '0;
            curLen    <= '0;
            bestStart <= '0;
            bestLen   <= '0;
        end else if (evalEn) begin
            curStart <= curStartNew;
            curLen   <= curLenNew;
            // Strictly greater so a later run of equal length never displaces the earliest one.
            if (curLenNew > bestLen) begin
                bestStart <= curStartNew;
                bestLen   <= curLenNew;
            end
        end
    end

    assign halfSpan  = (bestLen - 1'b1) >> 1;
    assign centreTap = bestStart + halfSpan[TAP_W-1:0];

endmodule

// File: rtl/clk_delay_tap_calib.sv
// Sweeps the pixel-clock delay taps, scores each with the pattern checker and locks the centre of the best window.
module clk_delay_tap_calib
    import clk_delay_pkg::*;
#(
    parameter int NTAPS       = NTAPS_DEF,
    parameter int TAP_W       = TAP_W_DEF,
    parameter int SETTLE_CYC  = 16,
    parameter int WINDOW_CYC  = 1024,
    parameter int MIN_VALID   = 64,
    parameter int DEFAULT_TAP = 0
) (
    input logic                 iCLK,
    input logic                 iRST,
    clk_delay_tap_calib_if.slave bus
);
    localparam int CNT_MAX = (SETTLE_CYC > WINDOW_CYC) ? SETTLE_CYC : WINDOW_CYC;
    localparam int CNT_W   = clog2(CNT_MAX + 1);
    localparam int VLD_W   = clog2(MIN_VALID + 1);
    localparam logic [TAP_W-1:0] LAST_TAP    = TAP_W'(NTAPS - 1);
    localparam logic [TAP_W-1:0] DEF_TAP     = TAP_W'(DEFAULT_TAP);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] WINDOW_LAST = CNT_W'(WINDOW_CYC - 1);
    localparam logic [VLD_W-1:0] VLD_SAT     = VLD_W'(MIN_VALID);

    calState_t        state, stateNxt;
    logic [CNT_W-1:0] cnt, cntNxt;
    logic [VLD_W-1:0] validCnt, validCntNxt;
    logic             errFlag, errFlagNxt;
    logic [TAP_W-1:0] tapSel, tapSelNxt, winStart, winStartNxt;
    logic [TAP_W:0]   winLen, winLenNxt;
    logic             busy, busyNxt, done, doneNxt, locked, lockedNxt, fail, failNxt;
    logic             abort, tapPass, trkClear, trkEval;
    logic [TAP_W-1:0] bestStart, centreTap, manualTap;
    logic [TAP_W:0]   bestLen;

    function automatic logic [TAP_W-1:0] clampTap(input logic [TAP_W-1:0] t);
        return (int'(t) >= NTAPS) ? LAST_TAP : t;
    endfunction

    assign manualTap = clampTap(bus.iMANUAL_TAP);
    assign abort     = (state != IDLE) && bus.iMANUAL_EN;
    assign tapPass   = !errFlag && (validCnt >= VLD_SAT);

    clk_delay_run_tracker #(.TAP_W(TAP_W)) uTracker (
        .clk       (iCLK),
        .rst       (iRST),
        .clear     (trkClear),
        .evalEn    (trkEval),
        .pass      (tapPass),
        .tap       (tapSel),
        .bestStart (bestStart),
        .bestLen   (bestLen),
        .centreTap (centreTap)
    );

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) state <= IDLE;
        else      state <= stateNxt;
    end

    always_comb begin
        stateNxt = state;
        case (state)
            IDLE:    if (bus.iSTART && !bus.iMANUAL_EN) stateNxt = SETTLE;
            SETTLE:  if (cnt == SETTLE_LAST) stateNxt = SAMPLE;
            SAMPLE:  if (cnt == WINDOW_LAST) stateNxt = EVAL;
            EVAL:    stateNxt = (tapSel == LAST_TAP) ? APPLY : SETTLE;
            APPLY:   stateNxt = IDLE;
            default: stateNxt = IDLE;
        endcase
        if (abort) stateNxt = IDLE;
    end

    always_comb begin
        cntNxt      = cnt;
        validCntNxt = validCnt;
        errFlagNxt  = errFlag;
        tapSelNxt   = tapSel;
        winStartNxt = winStart;
        winLenNxt   = winLen;
        busyNxt     = busy;
        doneNxt     = 1'b0;
        lockedNxt   = locked;
        failNxt     = fail;
        trkClear    = 1'b0;
        trkEval     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.iMANUAL_EN) begin
                    tapSelNxt = manualTap;
                end else if (bus.iSTART) begin
                    tapSelNxt = '0;
                    busyNxt   = 1'b1;
                    lockedNxt = 1'b0;
                    failNxt   = 1'b0;
                    cntNxt    = '0;
                    trkClear  = 1'b1;
                end
            end
            SETTLE: begin
                if (cnt == SETTLE_LAST) begin
                    cntNxt      = '0;
                    validCntNxt = '0;
                    errFlagNxt  = 1'b0;
                end else begin
                    cntNxt = cnt + 1'b1;
                end
            end
            SAMPLE: begin
                if (bus.iCHK_VALID && validCnt != VLD_SAT) validCntNxt = validCnt + 1'b1;
                if (bus.iCHK_VALID && bus.iCHK_ERR) errFlagNxt = 1'b1;
                cntNxt = (cnt == WINDOW_LAST) ? '0 : cnt + 1'b1;
            end
            EVAL: begin
                trkEval = 1'b1;
                if (tapSel != LAST_TAP) tapSelNxt = tapSel + 1'b1;
            end
            APPLY: begin
                if (bestLen != '0) begin
                    tapSelNxt = centreTap;
                    lockedNxt = 1'b1;
                end else begin
                    tapSelNxt = DEF_TAP;
                    failNxt   = 1'b1;
                end
                winStartNxt = bestStart;
                winLenNxt   = bestLen;
                doneNxt     = 1'b1;
                busyNxt     = 1'b0;
            end
            default: ;
        endcase
        // Manual takeover mid-sweep discards the sweep without reporting it.
        if (abort) begin
            tapSelNxt = manualTap;
            busyNxt   = 1'b0;
            doneNxt   = 1'b0;
            lockedNxt = 1'b0;
            failNxt   = 1'b0;
            trkEval   = 1'b0;
            cntNxt    = '0;
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            cnt      <= '0;
            validCnt <= '0;
            errFlag  <= 1'b0;
            tapSel   <= DEF_TAP;
            winStart <= '0;
            winLen   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            locked   <= 1'b0;
            fail     <= 1'b0;
        end else begin
            cnt      <= cntNxt;
            validCnt <= validCntNxt;
            errFlag  <= errFlagNxt;
            tapSel   <= tapSelNxt;
            winStart <= winStartNxt;
            winLen   <= winLenNxt;
            busy     <= busyNxt;
            done     <= doneNxt;
            locked   <= lockedNxt;
            fail     <= failNxt;
        end
    end

    assign bus.oTAP_SEL   = tapSel;
    assign bus.oBUSY      = busy;
    assign bus.oDONE      = done;
    assign bus.oLOCKED    = locked;
    assign bus.oFAIL      = fail;
    assign bus.oWIN_START = winStart;
    assign bus.oWIN_LEN   = winLen;

endmodule

// File: tb/tb_clk_delay_tap_calib.sv
// Directed bench for clk_delay_tap_calib: table of full sweeps plus abort, restart and reset sequences.
module tb_clk_delay_tap_calib;
    localparam int TAPW      = 4;
    localparam int SWEEP_LAT = 1 + 8 * (16 + 1024 + 1) + 1;

    logic clk;
    logic rst;
    int   nChecks = 0;
    int   nFail   = 0;

    logic [7:0] curErrMask = 8'h00;
    logic       curValidOn = 1'b0;

    clk_delay_tap_calib_if #(.TAP_W(TAPW)) bus ();

    clk_delay_tap_calib #(
        .NTAPS(8), .TAP_W(TAPW), .SETTLE_CYC(16), .WINDOW_CYC(1024),
        .MIN_VALID(64), .DEFAULT_TAP(0)
    ) dut (
        .iCLK (clk),
        .iRST (rst),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pattern checker model: result quality depends on the tap currently selected.
    always @(negedge clk) begin
        bus.iCHK_VALID = curValidOn;
        bus.iCHK_ERR   = curErrMask[bus.oTAP_SEL[2:0]];
    end

    typedef struct {
        string      name;
        logic [7:0] errMask;
        logic       validOn;
        int         expStart;
        int         expLen;
        int         expTap;
        int         expLocked;
        int         expFail;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Pulses iSTART for one cycle and runs maxCyc cycles, optionally re-pulsing iSTART at restartAt.
    task automatic runSweep(input int maxCyc, input int restartAt,
                            output int doneCycle, output int doneCount);
        doneCycle = -1;
        doneCount = 0;
        @(negedge clk);
        bus.iSTART = 1'b1;
        for (int c = 1; c <= maxCyc; c++) begin
            @(negedge clk);
            bus.iSTART = (c == restartAt);
            if (bus.oDONE === 1'b1) begin
                doneCount++;
                if (doneCycle < 0) doneCycle = c;
            end
        end
    endtask

    int dCyc, dCnt;

    initial begin
        vecs[0] = '{"allPass",  8'b0000_0000, 1'b1, 0, 8, 3, 1, 0};
        vecs[1] = '{"mid4",     8'b1100_0011, 1'b1, 2, 4, 3, 1, 0};
        vecs[2] = '{"tieRuns",  8'b1001_1001, 1'b1, 1, 2, 1, 1, 0};
        vecs[3] = '{"noValid",  8'b0000_0000, 1'b0, 0, 0, 0, 0, 1};

        rst             = 1'b1;
        bus.iSTART      = 1'b0;
        bus.iMANUAL_EN  = 1'b0;
        bus.iMANUAL_TAP = '0;
        #2;
        check("rstTap",    bus.oTAP_SEL, 0);
        check("rstBusy",   bus.oBUSY, 0);
        check("rstDone",   bus.oDONE, 0);
        check("rstLocked", bus.oLOCKED, 0);
        check("rstFail",   bus.oFAIL, 0);
        check("rstWinLen", bus.oWIN_LEN, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int v = 0; v < 4; v++) begin
            curErrMask = vecs[v].errMask;
            curValidOn = vecs[v].validOn;
            runSweep(SWEEP_LAT + 5, -1, dCyc, dCnt);
            check({vecs[v].name, ".doneCycle"}, dCyc, SWEEP_LAT);
            check({vecs[v].name, ".doneCount"}, dCnt, 1);
            check({vecs[v].name, ".winStart"},  bus.oWIN_START, vecs[v].expStart);
            check({vecs[v].name, ".winLen"},    bus.oWIN_LEN, vecs[v].expLen);
            check({vecs[v].name, ".tapSel"},    bus.oTAP_SEL, vecs[v].expTap);
            check({vecs[v].name, ".locked"},    bus.oLOCKED, vecs[v].expLocked);
            check({vecs[v].name, ".fail"},      bus.oFAIL, vecs[v].expFail);
            check({vecs[v].name, ".busy"},      bus.oBUSY, 0);
        end

        // Manual override in IDLE: follows with one cycle latency, holds on release, iSTART ignored.
        @(negedge clk);
        bus.iMANUAL_EN  = 1'b1;
        bus.iMANUAL_TAP = 4'd5;
        bus.iSTART      = 1'b1;
        @(negedge clk);
        bus.iSTART = 1'b0;
        check("manTap5",      bus.oTAP_SEL, 5);
        check("manStartBusy", bus.oBUSY, 0);
        check("manKeepFail",  bus.oFAIL, 1);
        bus.iMANUAL_EN = 1'b0;
        bus.iMANUAL_TAP = 4'd2;
        repeat (2) @(negedge clk);
        check("manHoldTap",   bus.oTAP_SEL, 5);

        // A second iSTART mid-sweep must not restart or duplicate the sweep.
        curErrMask = 8'h00;
        curValidOn = 1'b1;
        runSweep(SWEEP_LAT + 5, 3000, dCyc, dCnt);
        check("restart.doneCycle", dCyc, SWEEP_LAT);
        check("restart.doneCount", dCnt, 1);
        check("restart.tapSel",    bus.oTAP_SEL, 3);
        check("restart.locked",    bus.oLOCKED, 1);

        // Manual takeover during a sweep with an out-of-range tap.
        runSweep(3000, -1, dCyc, dCnt);
        check("abort.busyBefore", bus.oBUSY, 1);
        bus.iMANUAL_EN  = 1'b1;
        bus.iMANUAL_TAP = 4'd9;
        dCnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.oDONE === 1'b1) dCnt++;
        end
        check("abort.busy",   bus.oBUSY, 0);
        check("abort.tap",    bus.oTAP_SEL, 7);
        check("abort.locked", bus.oLOCKED, 0);
        check("abort.fail",   bus.oFAIL, 0);
        check("abort.noDone", dCnt, 0);
        bus.iMANUAL_TAP = 4'd2;
        @(negedge clk);
        check("abort.follow", bus.oTAP_SEL, 2);
        bus.iMANUAL_EN = 1'b0;

        // Asynchronous reset during SAMPLE of tap 4, then a clean restart from tap 0.
        runSweep(4165 + 16 + 100, -1, dCyc, dCnt);
        check("rstMid.tapBefore", bus.oTAP_SEL, 4);
        check("rstMid.busyBefore", bus.oBUSY, 1);
        #1;
        rst = 1'b1;
        #1;
        check("rstMid.tap",    bus.oTAP_SEL, 0);
        check("rstMid.busy",   bus.oBUSY, 0);
        check("rstMid.locked", bus.oLOCKED, 0);
        check("rstMid.winLen", bus.oWIN_LEN, 0);
        dCnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.oDONE === 1'b1) dCnt++;
        end
        check("rstMid.noDone", dCnt, 0);
        rst = 1'b0;
        runSweep(1041, -1, dCyc, dCnt);
        check("rerun.tap0", bus.oTAP_SEL, 0);
        check("rerun.busy", bus.oBUSY, 1);
        @(negedge clk);
        check("rerun.tap1", bus.oTAP_SEL, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end
endmodule

// File: doc/clk_delay_tap_calib.md
Name: clk_delay_tap_calib

Overview:
- Sequences the camera pixel-clock delay line: drives the tap-select of the lcell delay chain feeding the capture flops.
- Sweeps every tap, scores capture quality at each, and locks the tap at the centre of the longest error-free run.
- Sits between the D8M receive front end (whose pattern checker supplies compare results) and the tap mux on the delayed clock.
- Also provides manual tap override and status for the host.

Parameters:
- NTAPS, 8, number of delay taps (tap indices 0..NTAPS-1)
- TAP_W, 3, tap index width; must satisfy 2**TAP_W >= NTAPS
- SETTLE_CYC, 16, wait cycles after each tap change before scoring
- WINDOW_CYC, 1024, scoring window length in iCLK cycles
- MIN_VALID, 64, minimum checker results needed in a window for the tap to pass
- DEFAULT_TAP, 0, tap applied after reset and after a failed sweep

Ports:
- iCLK  in  1  system clock; all logic is on the rising edge
- iRST  in  1  asynchronous, active-high reset
- iSTART  in  1  one-cycle request to run a sweep
- iMANUAL_EN  in  1  forces oTAP_SEL to iMANUAL_TAP
- iMANUAL_TAP  in  TAP_W  manual tap index
- iCHK_VALID  in  1  checker result strobe
- iCHK_ERR  in  1  mismatch flag; qualified by iCHK_VALID
- oTAP_SEL  out  TAP_W  registered tap select to the delay mux
- oBUSY  out  1  high while a sweep runs
- oDONE  out  1  one-cycle pulse when a sweep ends, pass or fail
- oLOCKED  out  1  last sweep found a passing tap
- oFAIL  out  1  last sweep found no passing tap
- oWIN_START  out  TAP_W  first tap of the best run
- oWIN_LEN  out  TAP_W+1  length of the best run

Behaviour:
- Reset values: oTAP_SEL=DEFAULT_TAP, oWIN_START=0, oWIN_LEN=0; oBUSY, oDONE, oLOCKED and oFAIL are all 0. State is IDLE and all counters clear.
- FSM states: IDLE, SETTLE, SAMPLE, EVAL, APPLY.
- IDLE: when iSTART=1 and iMANUAL_EN=0:
  - next cycle: oTAP_SEL=0, oBUSY=1, oLOCKED=0, oFAIL=0;
  - best and current run trackers clear; go to SETTLE.
- iSTART is ignored while oBUSY=1 or iMANUAL_EN=1.
- SETTLE: count SETTLE_CYC cycles; checker strobes are discarded. Then go to SAMPLE with the error and valid counters cleared.
- SAMPLE: count WINDOW_CYC cycles.
  - Each cycle with iCHK_VALID=1 increments the valid counter, saturating at MIN_VALID.
  - Each cycle with iCHK_VALID&iCHK_ERR sets a sticky error flag.
  - Then go to EVAL.
- EVAL (one cycle): the tap passes if err=0 and valid>=MIN_VALID.
  - Pass: the current run extends (cur_len+1, cur_start set when cur_len was 0).
  - Fail: cur_len=0.
  - The best run updates only when cur_len_new > best_len, so ties keep the earliest run.
  - If tap < NTAPS-1: oTAP_SEL increments and the FSM goes to SETTLE. Otherwise go to APPLY.
- APPLY (one cycle):
  - If best_len>0: oTAP_SEL = best_start + (best_len-1)>>1 (floor centre), oLOCKED=1.
  - Otherwise: oTAP_SEL=DEFAULT_TAP, oFAIL=1.
  - oWIN_START and oWIN_LEN load from the best run; oDONE pulses; oBUSY falls; return to IDLE.
- Sweep latency from iSTART to oDONE: 1 + NTAPS*(SETTLE_CYC+WINDOW_CYC+1) + 1 cycles.
- Manual override: while iMANUAL_EN=1 in IDLE, oTAP_SEL takes iMANUAL_TAP each cycle (1-cycle register latency).
  - On deassert, oTAP_SEL holds the last manual value; the lock/fail status is unchanged.
  - iMANUAL_EN rising during a sweep aborts it: return to IDLE with oBUSY=0, no oDONE, oLOCKED=0, oFAIL=0, and oTAP_SEL following the manual tap.
- Tap indices >= NTAPS from iMANUAL_TAP clamp to NTAPS-1.
- iRST mid-sweep: immediate return to reset values; no oDONE.
- Counter widths: clog2(max(SETTLE_CYC, WINDOW_CYC)+1); valid counter clog2(MIN_VALID+1).

Decomposition:
- Shared package clk_delay_pkg: FSM state enum, the NTAPS/TAP_W defaults, and a clog2 function; shared with the delay-mux wrapper.
- One natural sub-module: clk_delay_run_tracker, covering the EVAL-stage current/best run logic and the centre computation. It is combinational plus registers, and unit-testable alone.

Test Plan:
- All taps pass (err=0, valid every cycle) -> oWIN_START=0, oWIN_LEN=8, oTAP_SEL=3, oLOCKED=1, oDONE once at cycle 1+8*1041+1.
- Errors on taps 0,1,6,7 only -> best run 2..5, oWIN_LEN=4, oTAP_SEL=3, oLOCKED=1.
- Two equal runs (1..2 and 5..6) -> earliest kept, oWIN_START=1, oTAP_SEL=1.
- No valid strobes at all -> every tap fails, oFAIL=1, oLOCKED=0, oTAP_SEL=DEFAULT_TAP, oWIN_LEN=0.
- iSTART again mid-sweep -> ignored, single oDONE. Then iMANUAL_EN=1 with tap 9 during the next sweep -> abort, no oDONE, oTAP_SEL=7.
- iRST asserted during SAMPLE of tap 4 -> all outputs at reset values the same cycle. Next iSTART restarts at tap 0.
